// File: rtl/lagd_axi_rd_fetcher.sv
// lagd_axi_rd_fetcher: AXI4 read initiator streaming a beat-aligned region out over valid/ready,
// split into INCR bursts of at most MaxBurstBeats that never cross a 4 KiB page.
module lagd_axi_rd_fetcher #(
   parameter int unsigned AddrWidth     = 48,
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned IdWidth       = 4,
   parameter int unsigned AxiId         = 0,
   parameter int unsigned LenWidth      = 16,
   parameter int unsigned MaxBurstBeats = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [AddrWidth-1:0] base_addr_i,
   input  logic [LenWidth-1:0]  num_beats_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic                 ar_valid_o,
   input  logic                 ar_ready_i,
   output logic [AddrWidth-1:0] ar_addr_o,
   output logic [7:0]           ar_len_o,
   output logic [2:0]           ar_size_o,
   output logic [1:0]           ar_burst_o,
   output logic [IdWidth-1:0]   ar_id_o,
   input  logic                 r_valid_i,
   output logic                 r_ready_o,
   input  logic [DataWidth-1:0] r_data_i,
   input  logic [1:0]           r_resp_i,
   input  logic                 r_last_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 data_valid_o,
   input  logic                 data_ready_i,
   output logic                 data_last_o
);
   localparam int unsigned OffW = $clog2(DataWidth / 8);
   localparam int unsigned CntW = (LenWidth > 13) ? LenWidth : 13;

   typedef enum logic [1:0] {IDLE, AR, R, DONE} state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [LenWidth-1:0]  rem_q, rem_d;
   logic                 err_q, err_d;
   logic [CntW-1:0]      page_beats, burst_lim, burst;
   logic                 in_r, r_fire;
   logic                 unused_bits;

   // Beats left before the next 4 KiB page boundary bound the burst alongside the cap and the remainder.
   assign page_beats  = (CntW'(4096) - CntW'(addr_q[11:0])) >> OffW;
   assign burst_lim   = (CntW'(MaxBurstBeats) < page_beats) ? CntW'(MaxBurstBeats) : page_beats;
   assign burst       = (CntW'(rem_q) < burst_lim) ? CntW'(rem_q) : burst_lim;
   assign in_r        = state_q == R;
   assign r_fire      = in_r && r_valid_i && data_ready_i;
   assign unused_bits = ^{base_addr_i[OffW-1:0], r_resp_i[0]};

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: if (start_i) begin
            addr_d  = {base_addr_i[AddrWidth-1:OffW], OffW'(0)};
            rem_d   = num_beats_i;
            err_d   = 1'b0;
            state_d = (num_beats_i == '0) ? DONE : AR;
         end
         AR: if (ar_ready_i) begin
            addr_d  = addr_q + (AddrWidth'(burst) << OffW);
            rem_d   = rem_q - LenWidth'(burst);
            state_d = R;
         end
         R: if (r_fire) begin
            err_d   = err_q | r_resp_i[1];
            state_d = !r_last_i ? R : (rem_q == '0) ? DONE : AR;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   assign busy_o       = (state_q != IDLE) || start_i;
   assign done_o       = state_q == DONE;
   assign err_o        = err_q;
   assign ar_valid_o   = state_q == AR;
   assign ar_addr_o    = ar_valid_o ? addr_q : '0;
   assign ar_len_o     = ar_valid_o ? 8'(burst - CntW'(1)) : '0;
   assign ar_size_o    = 3'(OffW);
   assign ar_burst_o   = 2'b01;
   assign ar_id_o      = IdWidth'(AxiId);
   assign r_ready_o    = in_r && data_ready_i;
   assign data_valid_o = in_r && r_valid_i;
   assign data_o       = in_r ? r_data_i : '0;
   assign data_last_o  = data_valid_o && r_last_i && (rem_q == '0);
endmodule

// File: tb/tb_lagd_axi_rd_fetcher.sv
// tb_lagd_axi_rd_fetcher: directed and randomized commands against an AXI slave model,
// checking bursts, stream order/data, last, err and busy/done against a page-split reference.
module tb_lagd_axi_rd_fetcher;
   logic        clk_i = 0, rst_ni = 0;
   logic        start_i = 0;
   logic [47:0] base_addr_i = '0;
   logic [15:0] num_beats_i = '0;
   logic        busy_o, done_o, err_o;
   logic        ar_valid_o, ar_ready_i = 0;
   logic [47:0] ar_addr_o;
   logic [7:0]  ar_len_o;
   logic [2:0]  ar_size_o;
   logic [1:0]  ar_burst_o;
   logic [3:0]  ar_id_o;
   logic        r_valid_i = 0, r_ready_o;
   logic [63:0] r_data_i = '0;
   logic [1:0]  r_resp_i = '0;
   logic        r_last_i = 0;
   logic [63:0] data_o;
   logic        data_valid_o, data_ready_i = 0, data_last_o;
   int checks = 0, errors = 0;

   lagd_axi_rd_fetcher dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
      .num_beats_i(num_beats_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
      .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o), .ar_id_o(ar_id_o), .r_valid_i(r_valid_i),
      .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i),
      .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_last_o(data_last_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mem(input logic [47:0] a);
      return (64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   function automatic logic rnd(input int stall_pct);
      return stall_pct == 0 ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
   endfunction

   // One command from start strobe to the cycle after done; called at posedge+1.
   task automatic run_cmd(input logic [47:0] base, input int beats, input int stall_pct,
                          input int err_beat, input bit poke);
      logic [47:0] qa[$];
      int          ql[$];
      logic [47:0] a, s_addr, p_addr;
      logic [7:0]  p_len;
      int rem, b, page, k = 0, cyc = 0, busy_cnt = 0, s_left = 0;
      bit done_seen = 0, exp_err = 0, sending = 0, p_stall = 0;
      a = {base[47:3], 3'b000};
      rem = beats;
      while (rem > 0) begin
         page = (4096 - int'(a[11:0])) / 8;
         b = rem < 16 ? rem : 16;
         b = b < page ? b : page;
         qa.push_back(a);
         ql.push_back(b);
         a = a + 48'(b * 8);
         rem -= b;
      end
      start_i = 1; base_addr_i = base; num_beats_i = 16'(beats);
      ar_ready_i = rnd(stall_pct); data_ready_i = rnd(stall_pct); r_valid_i = 0; r_last_i = 0;
      while (!done_seen && cyc < 3000) begin
         @(negedge clk_i);
         chk("busy", busy_o, 1);
         busy_cnt++;
         if (cyc == 1) chk("err_clear", err_o, 0);
         chk("r_ready", r_ready_o, sending ? data_ready_i : 1'b0);
         chk("data_valid", data_valid_o, sending && r_valid_i);
         if (sending || cyc == 0) chk("ar_quiet", ar_valid_o, 0);
         if (p_stall) begin
            chk("ar_hold_valid", ar_valid_o, 1);
            chk("ar_hold_addr", ar_addr_o, p_addr);
            chk("ar_hold_len", ar_len_o, p_len);
         end
         if (ar_valid_o && ar_ready_i) begin
            if (qa.size() == 0) chk("ar_extra", ar_valid_o, 0);
            else begin
               chk("ar_addr", ar_addr_o, qa[0]);
               chk("ar_len", ar_len_o, 64'(ql[0] - 1));
               void'(qa.pop_front());
               void'(ql.pop_front());
               sending = 1; s_addr = ar_addr_o; s_left = int'(ar_len_o) + 1;
            end
         end
         if (data_valid_o) chk("data_last", data_last_o, k == beats - 1);
         if (data_valid_o && data_ready_i) begin
            chk("data", data_o, mem(a - 48'((beats - k) * 8)));
            if (k == err_beat) exp_err = 1;
            k++;
            s_addr += 8;
            s_left--;
            if (s_left == 0) sending = 0;
         end
         if (done_o) begin
            done_seen = 1;
            chk("err_done", err_o, exp_err);
            chk("beats", k, beats);
            chk("ar_missing", qa.size(), 0);
            if (beats == 0) begin
               chk("done_cycle", cyc, 1);
               chk("busy_cycles", busy_cnt, 2);
            end
         end
         p_stall = ar_valid_o && !ar_ready_i; p_addr = ar_addr_o; p_len = ar_len_o;
         if (!done_seen) begin
            @(posedge clk_i); #1;
            cyc++;
            start_i = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (poke) begin base_addr_i = {16'($urandom), 32'($urandom)}; num_beats_i = 16'($urandom_range(0, 9)); end
            ar_ready_i = rnd(stall_pct); data_ready_i = rnd(stall_pct);
            r_valid_i = sending && rnd(stall_pct);
            r_data_i = sending ? mem(s_addr) : 64'($urandom);
            r_last_i = sending && s_left == 1;
            r_resp_i = (sending && k == err_beat) ? 2'b10 | 2'($urandom_range(0, 1)) : 2'b00;
         end
      end
      if (!done_seen) chk("timeout", done_o, 1);
      @(posedge clk_i); #1;
      start_i = 0; r_valid_i = 0; r_last_i = 0;
      @(negedge clk_i);
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
      @(posedge clk_i); #1;
   endtask

   initial begin
      logic [47:0] base;
      data_ready_i = 1; r_valid_i = 1;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_ar_valid", ar_valid_o, 0);
      chk("rst_ar_addr", ar_addr_o, 0);
      chk("rst_ar_len", ar_len_o, 0);
      chk("rst_r_ready", r_ready_o, 0);
      chk("rst_data_valid", data_valid_o, 0);
      chk("rst_data_last", data_last_o, 0);
      chk("ar_size", ar_size_o, 3);
      chk("ar_burst", ar_burst_o, 1);
      chk("ar_id", ar_id_o, 0);
      r_valid_i = 0;
      @(negedge clk_i) rst_ni = 1;
      @(posedge clk_i); #1;
      run_cmd(48'h0000_1000_0000, 4, 0, -1, 0);
      run_cmd(48'h0000_0000_0FF0, 8, 0, -1, 0);
      run_cmd(48'h0, 40, 0, -1, 0);
      run_cmd(48'h0000_2000_0F85, 20, 50, -1, 0);
      run_cmd(48'h0, 0, 0, -1, 0);
      run_cmd(48'h0000_0000_3000, 4, 0, 1, 1);
      run_cmd(48'h0000_0000_4000, 4, 0, -1, 0);
      run_cmd(48'hFFFF_FFFF_FFE0, 10, 30, -1, 0);
      for (int i = 0; i < 14; i++) begin
         base = {16'($urandom), 32'($urandom)};
         if (i % 2 == 0) base[11:0] = 12'hF80 | 12'($urandom_range(0, 127));
         run_cmd(base, $urandom_range(0, 70), 50, $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : -1,
                 1'($urandom_range(0, 1)));
      end
      start_i = 1; base_addr_i = 48'h0; num_beats_i = 16'd40; ar_ready_i = 0;
      @(posedge clk_i); #1;
      start_i = 0;
      @(posedge clk_i); #1;
      chk("pre_rst_ar_valid", ar_valid_o, 1);
      rst_ni = 0;
      #1;
      chk("async_rst_busy", busy_o, 0);
      chk("async_rst_ar_valid", ar_valid_o, 0);
      @(negedge clk_i) rst_ni = 1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
